nibble_serial_addsub_seq: RTL and testbench
===========================================

// Module: nibble_serial_addsub_seq
// PURPOSE
//  Sequences one 4-bit carry-lookahead add/sub slice across a WIDTH-bit operand, one nibble per clock.
//  Chains the carry between nibbles. Returns a full-width result and carry/borrow through valid/ready handshakes.
//  Sits between a requesting controller and the shared 4-bit CLA datapath; the slice is instantiated internally.
// PARAMETERS
//  WIDTH   16   operand/result width in bits; multiple of 4, >= 4
//  NIB     WIDTH/4 (localparam)   nibble count = RUN cycles per operation
// PORTS
//  clk          in   1      single clock; all state on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  start_valid  in   1      request present
//  start_ready  out  1      block can accept (IDLE only)
//  op_sub       in   1      0: a+b, 1: a-b; sampled at accept
//  a            in   WIDTH  operand A; sampled at accept
//  b            in   WIDTH  operand B; sampled at accept
//  res_valid    out  1      result held valid
//  res_ready    in   1      consumer takes result
//  res          out  WIDTH  result, mod 2^WIDTH
//  cout         out  1      add: carry-out of MSB; sub: borrow (= ~carry-out)
//  busy         out  1      high in RUN and DONE
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, nib_cnt=0, res=0, cout=0, res_valid=0, busy=0, start_ready=1 after release.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE -> RUN on start_valid&start_ready.
//    RUN -> DONE after nibble NIB-1.
//    DONE -> IDLE on res_ready.
//  - Accept (cycle T): latch a, b, op_sub. Carry register = op_sub (sub = a + ~b + 1). nib_cnt=0.
//  - RUN, cycle T+1+k, k=0..NIB-1: slice gets a[4k+3:4k], b or ~b nibble, and carry reg.
//    Sum nibble is written into res[4k+3:4k]; carry reg takes the slice carry-out.
//  - cout = carry reg after last nibble; inverted when op_sub=1.
//  - res_valid rises at cycle T+NIB+1. res and cout stay stable until the res_ready handshake.
//  - start_ready=0 in RUN and DONE. start_valid while busy is ignored, no queueing. No IDLE->RUN in the same cycle as DONE->IDLE.
//  - res_ready=1 in IDLE or RUN: no effect.
//  - Latched a/b/op_sub are immune to input changes after accept.
//  - res is not cleared on completion; it holds the last result in IDLE.
//  - Reset mid-RUN/DONE: operation discarded, all outputs return to reset values next cycle.
//  - nib_cnt is clog2(NIB) bits wide (min 1) and never wraps past NIB-1 within one operation.
// CONFIGURATION
//  OVF_FLAG_EN defined:
//    - Adds output port ovf (1 bit): signed overflow = carry-in XOR carry-out of the MSB of the top nibble.
//    - ovf updates with res; reset 0; held through DONE.
//  OVF_FLAG_EN undefined: no ovf port, no overflow logic; all other behaviour identical.
// TESTING (WIDTH=16 unless noted)
//  1. add 0x1234+0x0FFF, res_ready=1 -> res=0x2233, cout=0, res_valid at accept+5, back to IDLE next cycle
//  2. sub 0x0000-0x0001 -> res=0xFFFF, cout(borrow)=1; sub 0x5000-0x1000 -> res=0x4000, cout=0
//  3. add 0xFFFF+0x0001 -> res=0x0000, cout=1; WIDTH=4: 0xF+0x1 -> res=0x0, cout=1, res_valid at accept+2
//  4. hold res_ready=0 10 cycles; pulse start_valid and change a/b meanwhile -> res stable, start_ready=0, no new accept
//  5. rst_n=0 at accept+2 -> next cycle IDLE, res_valid=0, res=0, busy=0; next op runs correctly
//  6. OVF_FLAG_EN: add 0x7FFF+0x0001 -> res=0x8000, ovf=1, cout=0; sub 0x8000-0x0001 -> res=0x7FFF, ovf=1

Source files
------------

// File: rtl/nibble_serial_addsub_seq.sv
// Nibble-serial add/subtract: one 4-bit carry-lookahead slice is reused over WIDTH/4 clocks.
// Define OVF_FLAG_EN to add the signed-overflow output port ovf.

module nibble_serial_addsub_cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       c3_o,
    output logic       cout_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Each carry is a flat two-level expression of the generate/propagate terms.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o  = p ^ c[3:0];
    assign c3_o   = c[3];
    assign cout_o = c[4];
endmodule

module nibble_serial_addsub_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             busy
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    nib_cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_sub_q;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             cout_q;
    logic             ovf_q;
    logic             res_valid_q;
    logic             busy_q;
    logic             start_ready_q;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] sum_nib;
    logic       slice_c3;
    logic       slice_c4;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (nib_cnt_q == CW'(k)) begin
                a_nib = a_q[4*k +: 4];
                b_nib = b_q[4*k +: 4];
            end
        end
        if (op_sub_q) begin
            b_nib = ~b_nib;
        end
    end

    nibble_serial_addsub_cla4 u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (sum_nib),
        .c3_o   (slice_c3),
        .cout_o (slice_c4)
    );

    always_comb begin
        res_d = res_q;
        for (int k = 0; k < NIB; k++) begin
            if (nib_cnt_q == CW'(k)) begin
                res_d[4*k +: 4] = sum_nib;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: a_q/b_q/op_sub_q are pure datapath and reloaded at every accept, so they carry no reset.
            state_q       <= IDLE;
            nib_cnt_q     <= '0;
            carry_q       <= 1'b0;
            res_q         <= '0;
            cout_q        <= 1'b0;
            ovf_q         <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid && start_ready_q) begin
                        a_q           <= a;
                        b_q           <= b;
                        op_sub_q      <= op_sub;
                        carry_q       <= op_sub;  // subtraction is a + ~b + 1
                        nib_cnt_q     <= '0;
                        state_q       <= RUN;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= slice_c4;
                    if (nib_cnt_q == LAST_NIB) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        cout_q      <= slice_c4 ^ op_sub_q;
                        ovf_q       <= slice_c3 ^ slice_c4;
                    end else begin
                        nib_cnt_q <= nib_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q       <= IDLE;
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign res         = res_q;
    assign cout        = cout_q;
    assign busy        = busy_q;
`ifdef OVF_FLAG_EN
    assign ovf         = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf  = ovf_q ^ slice_c3;
`endif
endmodule

// File: tb/tb_nibble_serial_addsub_seq.sv
// Scoreboard bench for nibble_serial_addsub_seq: a driver queues expected results, a negedge monitor checks them.
// Runs the OVF_FLAG_EN checks only when that macro is defined.

module tb_nibble_serial_addsub_seq;
    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid, op_sub, res_ready;
    logic [15:0] a, b;
    logic        start_ready, res_valid, cout, busy;
    logic [15:0] res;

    logic       s4_start_valid, s4_op_sub, s4_res_ready;
    logic [3:0] s4_a, s4_b, s4_res;
    logic       s4_start_ready, s4_res_valid, s4_cout, s4_busy;
`ifdef OVF_FLAG_EN
    logic ovf, s4_ovf;
`endif

    always #5 clk = ~clk;

    nibble_serial_addsub_seq #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_sub      (op_sub),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .cout        (cout),
        .busy        (busy)
`ifdef OVF_FLAG_EN
        , .ovf       (ovf)
`endif
    );

    nibble_serial_addsub_seq #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (s4_start_valid),
        .start_ready (s4_start_ready),
        .op_sub      (s4_op_sub),
        .a           (s4_a),
        .b           (s4_b),
        .res_valid   (s4_res_valid),
        .res_ready   (s4_res_ready),
        .res         (s4_res),
        .cout        (s4_cout),
        .busy        (s4_busy)
`ifdef OVF_FLAG_EN
        , .ovf       (s4_ovf)
`endif
    );

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic c, input logic o);
        exp_t e;
        e.res  = r;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    // Monitor: samples on the falling edge, driver acts at posedge+1.
    logic prev_valid = 1'b0;
    logic idle_chk = 1'b0;
    int   rise_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        int   acc;
        if (rst_n) begin
            if (idle_chk) begin
                check("idle_start_ready", start_ready, 1);
                check("idle_busy", busy, 0);
                check("idle_res_valid", res_valid, 0);
                idle_chk = 1'b0;
            end
            if (res_valid && !prev_valid) rise_cyc = cyc;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    check("res", res, e.res);
                    check("cout", cout, e.cout);
`ifdef OVF_FLAG_EN
                    check("ovf", ovf, e.ovf);
`endif
                    check("latency", rise_cyc - acc, NIB);
                    idle_chk = 1'b1;
                end
            end
        end
        prev_valid = res_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sub, input logic [15:0] va, input logic [15:0] vb,
                         input exp_t e, input bit push);
        int n = 0;
        while (!start_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) fail("start_ready_wait");
        start_valid = 1'b1;
        op_sub      = sub;
        a           = va;
        b           = vb;
        step();
        if (push) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        start_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) fail("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; res_ready = 1'b1;
        s4_start_valid = 1'b0; s4_op_sub = 1'b0; s4_a = '0; s4_b = '0; s4_res_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_res_valid", res_valid, 0);
        check("rst_res", res, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        check("rst_start_ready", start_ready, 1);
        rst_n = 1'b1;
        step();

        // Directed vectors with hand-computed results
        issue(1'b0, 16'h1234, 16'h0FFF, mk(16'h2233, 1'b0, 1'b0), 1);
        issue(1'b1, 16'h0000, 16'h0001, mk(16'hFFFF, 1'b1, 1'b0), 1);
        issue(1'b1, 16'h5000, 16'h1000, mk(16'h4000, 1'b0, 1'b0), 1);
        issue(1'b0, 16'hFFFF, 16'h0001, mk(16'h0000, 1'b1, 1'b0), 1);
        issue(1'b1, 16'h1234, 16'h1234, mk(16'h0000, 1'b0, 1'b0), 1);
        issue(1'b0, 16'h8000, 16'h8000, mk(16'h0000, 1'b1, 1'b1), 1);
        issue(1'b0, 16'h7FFF, 16'h0001, mk(16'h8000, 1'b0, 1'b1), 1);
        issue(1'b1, 16'h8000, 16'h0001, mk(16'h7FFF, 1'b0, 1'b1), 1);
        drain();

        // Back-pressure: result must hold while new requests are ignored
        res_ready = 1'b0;
        issue(1'b0, 16'hA5A5, 16'h5A5A, mk(16'hFFFF, 1'b0, 1'b0), 1);
        n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) fail("hold_valid_wait");
        for (int i = 0; i < 10; i++) begin
            check("hold_res", res, 16'hFFFF);
            check("hold_cout", cout, 0);
            check("hold_start_ready", start_ready, 0);
            check("hold_res_valid", res_valid, 1);
            start_valid = i[0];
            op_sub      = ~i[0];
            a           = 16'($urandom);
            b           = 16'($urandom);
            step();
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        drain();
        issue(1'b0, 16'h0101, 16'h0202, mk(16'h0303, 1'b0, 1'b0), 1);
        drain();

        // Reset two cycles after accept discards the operation
        issue(1'b0, 16'h1111, 16'h2222, mk(16'h0000, 1'b0, 1'b0), 0);
        step();
        rst_n = 1'b0;
        step();
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res", res, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cout", cout, 0);
        check("midrst_start_ready", start_ready, 1);
        rst_n = 1'b1;
        step();
        issue(1'b1, 16'h9000, 16'h0FFF, mk(16'h8001, 1'b0, 1'b0), 1);
        drain();

        // WIDTH=4 instance: single-nibble operation
        s4_start_valid = 1'b1;
        s4_a = 4'hF;
        s4_b = 4'h1;
        step();
        s4_start_valid = 1'b0;
        n = 0;
        while (!s4_res_valid && n < 20) begin
            step();
            n++;
        end
        check("w4_latency", n, 1);
        check("w4_res", s4_res, 0);
        check("w4_cout", s4_cout, 1);
`ifdef OVF_FLAG_EN
        check("w4_ovf", s4_ovf, 0);
`endif
        step();
        check("w4_idle", s4_start_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
